// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MIPS 16-bit processor front end.
//   - Default address / instruction widths and sequential PC step.
//   - Opcode and funct encodings shared between fetch and MIPS_Control.
//   - Fetch sequencer state encoding.
package mips_pkg;

    localparam int unsigned MIPS_ADDR_W  = 16;
    localparam int unsigned MIPS_INSTR_W = 32;
    localparam int unsigned MIPS_PC_STEP = 4;

    // Primary opcodes, IR[31:26]
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;  // BLTZ / BGEZ
    localparam logic [5:0] OP_JUMP  = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLEZ  = 6'h06;
    localparam logic [5:0] OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes, IR[5:0]
    localparam logic [5:0] FN_SLL     = 6'h00;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_SYSCALL = 6'h0C;
    localparam logic [5:0] FN_ADD     = 6'h20;
    localparam logic [5:0] FN_SUB     = 6'h22;
    localparam logic [5:0] FN_AND     = 6'h24;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_SLT     = 6'h2A;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StHold,
        StHalt
    } fetch_state_e;

endpackage

// File: rtl/mips_next_pc.sv
// mips_next_pc: combinational next-PC resolution for the held instruction.
// Ports:
//   pc_out                  PC of the held instruction
//   ir                      held instruction
//   br_eq..br_lt, j         branch/jump selects from MIPS_Control
//   cmp_eq, rs_neg, rs_zero datapath compare flags
//   next_pc                 address of the next instruction to fetch
// Priority: jump, then taken branch, then sequential. Among branch selects the
// first asserted one decides taken/not-taken; later selects are not consulted.
module mips_next_pc
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W  = MIPS_ADDR_W,
    parameter int unsigned INSTR_W = MIPS_INSTR_W,
    parameter int unsigned PC_STEP = MIPS_PC_STEP
) (
    input  logic [ADDR_W-1:0]  pc_out,
    input  logic [INSTR_W-1:0] ir,
    input  logic               br_eq,
    input  logic               br_ne,
    input  logic               br_gt,
    input  logic               br_gt_eq_z,
    input  logic               br_lt,
    input  logic               j,
    input  logic               cmp_eq,
    input  logic               rs_neg,
    input  logic               rs_zero,
    output logic [ADDR_W-1:0]  next_pc
);

    logic [ADDR_W+15:0] imm_sext;
    logic [ADDR_W-1:0]  br_off;
    logic [ADDR_W-1:0]  seq_pc;
    logic [ADDR_W-1:0]  jump_pc;
    logic               taken;
    logic               unused_ir;

    // Sign-extend the 16-bit immediate, word-scale it, keep ADDR_W bits.
    assign imm_sext  = {{ADDR_W{ir[15]}}, ir[15:0]};
    assign br_off    = {imm_sext[ADDR_W-3:0], 2'b00};
    assign seq_pc    = pc_out + ADDR_W'(PC_STEP);
    assign jump_pc   = {ir[ADDR_W-3:0], 2'b00};
    assign unused_ir = ^ir[INSTR_W-1:16];

    always_comb begin
        taken = 1'b0;
        if (br_eq) begin
            taken = cmp_eq;
        end else if (br_ne) begin
            taken = !cmp_eq;
        end else if (br_gt) begin
            taken = !rs_neg && !rs_zero;
        end else if (br_gt_eq_z) begin
            taken = !rs_neg;
        end else if (br_lt) begin
            taken = rs_neg;
        end
    end

    always_comb begin
        next_pc = seq_pc;
        if (j) begin
            next_pc = jump_pc;
        end else if (taken) begin
            next_pc = seq_pc + br_off;
        end
    end

endmodule

// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit: instruction fetch and PC sequencing ahead of MIPS_Control.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   imem_req/addr/ack/rdata  instruction memory handshake (req held until ack)
//   instr_valid/ready        held instruction offered to / retired by execute
//   instr, instr_code,       held IR and its opcode / funct fields
//   alu_funct
//   pc_out                   PC of the held instruction
//   br_*, j, clk_off         controller outputs, sampled on the retire cycle
//   cmp_eq, rs_neg, rs_zero  datapath compare flags, sampled on the retire cycle
//   halted                   sticky after SYSCALL until reset
module mips_fetch_unit
    import mips_pkg::*;
#(
    parameter int unsigned        ADDR_W   = MIPS_ADDR_W,
    parameter int unsigned        INSTR_W  = MIPS_INSTR_W,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter int unsigned        PC_STEP  = MIPS_PC_STEP
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [5:0]         instr_code,
    output logic [5:0]         alu_funct,
    output logic [ADDR_W-1:0]  pc_out,
    input  logic               br_eq,
    input  logic               br_ne,
    input  logic               br_gt,
    input  logic               br_gt_eq_z,
    input  logic               br_lt,
    input  logic               j,
    input  logic               clk_off,
    input  logic               cmp_eq,
    input  logic               rs_neg,
    input  logic               rs_zero,
    output logic               halted
);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  pc_out_q, pc_out_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  next_pc;

    mips_next_pc #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W),
        .PC_STEP (PC_STEP)
    ) u_next_pc (
        .pc_out     (pc_out_q),
        .ir         (instr_q),
        .br_eq      (br_eq),
        .br_ne      (br_ne),
        .br_gt      (br_gt),
        .br_gt_eq_z (br_gt_eq_z),
        .br_lt      (br_lt),
        .j          (j),
        .cmp_eq     (cmp_eq),
        .rs_neg     (rs_neg),
        .rs_zero    (rs_zero),
        .next_pc    (next_pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            pc_q     <= RESET_PC;
            pc_out_q <= RESET_PC;
            instr_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pc_out_q <= pc_out_d;
            instr_q  <= instr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pc_out_d    = pc_out_q;
        instr_d     = instr_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        halted      = 1'b0;

        unique case (state_q)
            StIdle: begin
                state_d = StFetch;
            end
            StFetch: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    instr_d  = imem_rdata;
                    pc_out_d = pc_q;
                    state_d  = StHold;
                end
            end
            StHold: begin
                instr_valid = 1'b1;
                // Controller and compare inputs only matter on the retire cycle.
                if (instr_ready) begin
                    if (clk_off) begin
                        state_d = StHalt;
                    end else begin
                        pc_d    = next_pc;
                        state_d = StFetch;
                    end
                end
            end
            StHalt: begin
                halted = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign imem_addr  = pc_q;
    assign instr      = instr_q;
    assign instr_code = instr_q[31:26];
    assign alu_funct  = instr_q[5:0];
    assign pc_out     = pc_out_q;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// tb_mips_fetch_unit: directed bench for mips_fetch_unit. A table of held
// instructions with controller/compare flags and the expected next fetch
// address, plus hand sequences for wait states, stalls, halt and reset.
module tb_mips_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [5:0]  instr_code;
    logic [5:0]  alu_funct;
    logic [15:0] pc_out;
    logic        br_eq = 1'b0, br_ne = 1'b0, br_gt = 1'b0, br_gt_eq_z = 1'b0, br_lt = 1'b0;
    logic        j = 1'b0, clk_off = 1'b0;
    logic        cmp_eq = 1'b0, rs_neg = 1'b0, rs_zero = 1'b0;
    logic        halted;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mips_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_code  (instr_code),
        .alu_funct   (alu_funct),
        .pc_out      (pc_out),
        .br_eq       (br_eq),
        .br_ne       (br_ne),
        .br_gt       (br_gt),
        .br_gt_eq_z  (br_gt_eq_z),
        .br_lt       (br_lt),
        .j           (j),
        .clk_off     (clk_off),
        .cmp_eq      (cmp_eq),
        .rs_neg      (rs_neg),
        .rs_zero     (rs_zero),
        .halted      (halted)
    );

    // flags = {br_eq, br_ne, br_gt, br_gt_eq_z, br_lt, j}
    typedef struct {
        logic [15:0] pc;
        logic [31:0] ir;
        logic [5:0]  flags;
        logic        ce;
        logic        rn;
        logic        rz;
        logic [15:0] exp;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic set_flags(input logic [5:0] f, input logic ce, input logic rn,
                             input logic rz, input logic off);
        {br_eq, br_ne, br_gt, br_gt_eq_z, br_lt, j} = f;
        cmp_eq  = ce;
        rs_neg  = rn;
        rs_zero = rz;
        clk_off = off;
    endtask

    // Wait for the request, hold off the ack for 'waits' cycles, then deliver.
    task automatic fetch(input logic [15:0] exp_addr, input logic [31:0] data, input int waits);
        int n = 0;
        while (!imem_req && n < 20) begin
            step();
            n++;
        end
        chk("fetch_req", 32'(imem_req), 32'd1);
        chk("fetch_addr", 32'(imem_addr), 32'(exp_addr));
        for (int w = 0; w < waits; w++) begin
            step();
            chk("wait_addr_stable", {15'd0, imem_req, imem_addr}, {15'd0, 1'b1, exp_addr});
            chk("wait_no_valid", 32'(instr_valid), 32'd0);
        end
        imem_ack   = 1'b1;
        imem_rdata = data;
        step();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        chk("held_valid", 32'(instr_valid), 32'd1);
        chk("held_instr", instr, data);
        chk("held_pc_out", 32'(pc_out), 32'(exp_addr));
    endtask

    task automatic retire(input logic [5:0] f, input logic ce, input logic rn, input logic rz,
                          input logic [15:0] exp_addr);
        set_flags(f, ce, rn, rz, 1'b0);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        set_flags(6'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("next_req", 32'(imem_req), 32'd1);
        chk("next_addr", 32'(imem_addr), 32'(exp_addr));
    endtask

    initial begin
        logic [15:0] cur;

        vecs[0]  = '{16'h0010, 32'h10220003, 6'b100000, 1'b1, 1'b0, 1'b0, 16'h0020};
        vecs[1]  = '{16'h0010, 32'h10220003, 6'b100000, 1'b0, 1'b0, 1'b0, 16'h0014};
        vecs[2]  = '{16'h0008, 32'h1422FFFE, 6'b010000, 1'b0, 1'b0, 1'b0, 16'h0004};
        vecs[3]  = '{16'h0008, 32'h1422FFFE, 6'b010000, 1'b1, 1'b0, 1'b0, 16'h000C};
        vecs[4]  = '{16'h0008, 32'h1C200005, 6'b001000, 1'b0, 1'b0, 1'b1, 16'h000C};
        vecs[5]  = '{16'h0008, 32'h1C200005, 6'b001000, 1'b0, 1'b0, 1'b0, 16'h0020};
        vecs[6]  = '{16'h0040, 32'h04210004, 6'b000100, 1'b0, 1'b0, 1'b1, 16'h0054};
        vecs[7]  = '{16'h0040, 32'h04210004, 6'b000100, 1'b0, 1'b1, 1'b0, 16'h0044};
        vecs[8]  = '{16'h0040, 32'h0420FFF0, 6'b000010, 1'b0, 1'b1, 1'b0, 16'h0004};
        vecs[9]  = '{16'h0040, 32'h0420FFF0, 6'b000010, 1'b0, 1'b0, 1'b0, 16'h0044};
        // Jump beats a simultaneously asserted, satisfied br_eq.
        vecs[10] = '{16'h0030, 32'h08000040, 6'b100001, 1'b1, 1'b0, 1'b0, 16'h0100};
        // br_eq decides (not taken) even though br_ne would have been taken.
        vecs[11] = '{16'h0010, 32'h10220003, 6'b110000, 1'b0, 1'b0, 1'b0, 16'h0014};
        // Sequential step wraps at the top of the address space.
        vecs[12] = '{16'hFFFC, 32'h20010005, 6'b000000, 1'b0, 1'b0, 1'b0, 16'h0000};

        // Reset state
        step();
        step();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc_out", 32'(pc_out), 32'd0);
        rst = 1'b0;
        step();

        // First fetch with two wait states
        fetch(16'h0000, 32'h20010005, 2);
        chk("addi_code", 32'(instr_code), 32'h08);
        chk("addi_funct", 32'(alu_funct), 32'h05);
        retire(6'b0, 1'b0, 1'b0, 1'b0, 16'h0004);
        cur = 16'h0004;

        // Table: jump to the vector's PC, fetch it, retire with its flags.
        for (int i = 0; i < NVEC; i++) begin
            fetch(cur, {6'h02, 12'h000, vecs[i].pc[15:2]}, i % 2);
            retire(6'b000001, 1'b0, 1'b0, 1'b0, vecs[i].pc);
            fetch(vecs[i].pc, vecs[i].ir, i % 3);
            chk($sformatf("vec%0d_code", i), 32'(instr_code), 32'(vecs[i].ir[31:26]));
            retire(vecs[i].flags, vecs[i].ce, vecs[i].rn, vecs[i].rz, vecs[i].exp);
            cur = vecs[i].exp;
        end

        // Stall in HOLD: held state frozen, retire-time inputs ignored meanwhile.
        fetch(cur, 32'h00221020, 0);
        set_flags(6'b000001, 1'b1, 1'b1, 1'b1, 1'b1);
        imem_ack = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("stall_state", {instr_valid, imem_req, halted, 13'd0, pc_out},
                {1'b1, 1'b0, 1'b0, 13'd0, cur});
            chk("stall_instr", instr, 32'h00221020);
        end
        imem_ack = 1'b0;
        set_flags(6'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        retire(6'b0, 1'b0, 1'b0, 1'b0, cur + 16'd4);
        cur = cur + 16'd4;

        // SYSCALL halt; halt wins over a simultaneous jump.
        fetch(cur, 32'h0000000C, 1);
        chk("sys_funct", 32'(alu_funct), 32'h0C);
        set_flags(6'b000001, 1'b0, 1'b0, 1'b0, 1'b1);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        set_flags(6'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        imem_ack = 1'b1;
        for (int k = 0; k < 50; k++) begin
            chk("halt_state", {29'd0, halted, imem_req, instr_valid}, 32'b100);
            step();
        end
        imem_ack = 1'b0;
        chk("halt_instr", instr, 32'h0000000C);

        // Reset leaves halt and restarts at RESET_PC
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("unhalt", 32'(halted), 32'd0);
        step();
        fetch(16'h0000, 32'h20010005, 0);
        retire(6'b0, 1'b0, 1'b0, 1'b0, 16'h0004);

        // Reset in FETCH with an ack in the same cycle: ack discarded.
        rst        = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEADBEEF;
        step();
        rst = 1'b0;
        chk("rstf_instr", instr, 32'd0);
        chk("rstf_req", 32'(imem_req), 32'd0);
        step();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        chk("rstf_instr2", instr, 32'd0);
        chk("rstf_valid", 32'(instr_valid), 32'd0);
        chk("rstf_refetch", {15'd0, imem_req, imem_addr}, {15'd0, 1'b1, 16'h0000});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
